// File: rtl/floor_call_register.sv
// floor_call_register
//   Registered front end of the floor-selection path. Binary floor calls are
//   decoded into a one-hot pending vector that feeds the priority encoder's d
//   input. When the car arrives at a called floor, that call is cleared and the
//   door-open timer runs.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | door closed; arrivals at called floors are serviced
//   DOOR  | door open; down-counter runs, arrivals ignored
//
// Ports
//   clk, rst                    system clock, synchronous active-high reset
//   req_valid, req_floor        floor call request
//   arrive_valid, arrive_floor  car level with a floor
//   pending, pending_any        outstanding calls and their OR
//   req_ack, req_drop           1-cycle accept / out-of-range reject pulses
//   served_valid, served_floor  1-cycle service pulse, floor held until next
//   door_open                   door open, car must not move
module floor_call_register #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = 3,
  parameter int DOOR_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  arrive_valid,
  input  logic [FLOOR_W-1:0]    arrive_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  pending_any,
  output logic                  req_ack,
  output logic                  req_drop,
  output logic                  served_valid,
  output logic [FLOOR_W-1:0]    served_floor,
  output logic                  door_open
);

  localparam int CNT_W = $clog2(DOOR_CYCLES);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DOOR_CYCLES - 1);
  // One extra bit so NUM_FLOORS == 2**FLOOR_W does not wrap to zero.
  localparam logic [FLOOR_W:0] FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

  typedef enum logic {
    IDLE = 1'b0,
    DOOR = 1'b1
  } state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [NUM_FLOORS-1:0]   pending_n;
  logic [NUM_FLOORS-1:0]   req_hot, arr_hot, avail;
  logic                    req_in_range, arr_in_range, arr_hit, door_hold;
  logic                    served_valid_n;
  logic [FLOOR_W-1:0]      served_floor_n;

  always_comb begin
    req_in_range   = {1'b0, req_floor} < FLOOR_LIMIT;
    arr_in_range   = {1'b0, arrive_floor} < FLOOR_LIMIT;
    req_hot        = '0;
    arr_hot        = '0;
    if (req_valid && req_in_range)
      req_hot = NUM_FLOORS'(1) << req_floor;
    if (arrive_valid && arr_in_range)
      arr_hot = NUM_FLOORS'(1) << arrive_floor;
    // A call arriving in the same cycle as the car counts as already pending.
    avail          = pending | req_hot;
    arr_hit        = |(avail & arr_hot);
    // A call to the floor whose door is open is absorbed and holds the door.
    door_hold      = req_valid && req_in_range && (req_floor == served_floor);

    state_n        = state;
    cnt_n          = cnt;
    pending_n      = pending;
    served_valid_n = 1'b0;
    served_floor_n = served_floor;

    case (state)
      IDLE: begin
        if (arr_hit) begin
          pending_n      = avail & ~arr_hot;
          served_valid_n = 1'b1;
          served_floor_n = arrive_floor;
          cnt_n          = CNT_RELOAD;
          state_n        = DOOR;
        end else begin
          pending_n = avail;
        end
      end
      DOOR: begin
        if (door_hold) begin
          cnt_n = CNT_RELOAD;
        end else begin
          pending_n = avail;
          if (cnt == '0)
            state_n = IDLE;
          else
            cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pending      <= '0;
      pending_any  <= 1'b0;
      req_ack      <= 1'b0;
      req_drop     <= 1'b0;
      served_valid <= 1'b0;
      served_floor <= '0;
      door_open    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      pending      <= pending_n;
      pending_any  <= |pending_n;
      req_ack      <= req_valid && req_in_range;
      req_drop     <= req_valid && !req_in_range;
      served_valid <= served_valid_n;
      served_floor <= served_floor_n;
      door_open    <= (state_n == DOOR);
    end
  end

endmodule

// File: tb/tb_floor_call_register.sv
module tb_floor_call_register;

  logic       clk, rst;
  logic       req_valid, arrive_valid;
  logic [2:0] req_floor, arrive_floor;

  logic [7:0] p8;
  logic       pa8, ack8, drop8, sv8, do8;
  logic [2:0] sf8;
  logic [5:0] p6;
  logic       pa6, ack6, drop6, sv6, do6;
  logic [2:0] sf6;

  int vectors = 0;
  int miscompares = 0;

  floor_call_register u8 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_floor(req_floor),
    .arrive_valid(arrive_valid), .arrive_floor(arrive_floor),
    .pending(p8), .pending_any(pa8), .req_ack(ack8), .req_drop(drop8),
    .served_valid(sv8), .served_floor(sf8), .door_open(do8)
  );

  floor_call_register #(.NUM_FLOORS(6), .FLOOR_W(3), .DOOR_CYCLES(16)) u6 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_floor(req_floor),
    .arrive_valid(arrive_valid), .arrive_floor(arrive_floor),
    .pending(p6), .pending_any(pa6), .req_ack(ack6), .req_drop(drop6),
    .served_valid(sv6), .served_floor(sf6), .door_open(do6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    req_valid    = 1'b0;
    req_floor    = 3'd0;
    arrive_valid = 1'b0;
    arrive_floor = 3'd0;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++; if (p8 !== 8'h00) begin miscompares++; $display("FAIL reset_pending got %h want 00", p8); end
    vectors++; if (pa8 !== 1'b0) begin miscompares++; $display("FAIL reset_pending_any got %b want 0", pa8); end
    vectors++; if ({ack8, drop8, sv8, do8} !== 4'b0000) begin miscompares++; $display("FAIL reset_pulses got %b want 0000", {ack8, drop8, sv8, do8}); end
    vectors++; if (sf8 !== 3'd0) begin miscompares++; $display("FAIL reset_served_floor got %0d want 0", sf8); end
    vectors++; if (p6 !== 6'h00) begin miscompares++; $display("FAIL reset_pending6 got %h want 00", p6); end
  endtask

  task automatic test_call();
    req_valid = 1'b1; req_floor = 3'd5;
    tick();
    quiet();
    vectors++; if (p8 !== 8'h20) begin miscompares++; $display("FAIL call_pending got %h want 20", p8); end
    vectors++; if (pa8 !== 1'b1) begin miscompares++; $display("FAIL call_pending_any got %b want 1", pa8); end
    vectors++; if (ack8 !== 1'b1) begin miscompares++; $display("FAIL call_ack got %b want 1", ack8); end
    tick();
    vectors++; if (ack8 !== 1'b0) begin miscompares++; $display("FAIL call_ack_pulse got %b want 0", ack8); end
    req_valid = 1'b1; req_floor = 3'd5;
    tick();
    quiet();
    vectors++; if ({ack8, p8} !== {1'b1, 8'h20}) begin miscompares++; $display("FAIL call_repeat got ack=%b p=%h want ack=1 p=20", ack8, p8); end
    req_valid = 1'b1; req_floor = 3'd2;
    tick();
    quiet();
    vectors++; if (p8 !== 8'h24) begin miscompares++; $display("FAIL call_second got %h want 24", p8); end
  endtask

  task automatic test_serve();
    int  n;
    logic sv_seen;
    arrive_valid = 1'b1; arrive_floor = 3'd5;
    tick();
    quiet();
    vectors++; if (p8 !== 8'h04) begin miscompares++; $display("FAIL serve_pending got %h want 04", p8); end
    vectors++; if ({sv8, sf8, do8} !== {1'b1, 3'd5, 1'b1}) begin miscompares++; $display("FAIL serve_outputs got sv=%b sf=%0d do=%b want 1 5 1", sv8, sf8, do8); end
    n = 1;
    sv_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) begin arrive_valid = 1'b1; arrive_floor = 3'd2; end
      else arrive_valid = 1'b0;
      tick();
      if (sv8) sv_seen = 1'b1;
      if (!do8) break;
      n++;
    end
    quiet();
    vectors++; if (n !== 16) begin miscompares++; $display("FAIL serve_door_len got %0d want 16", n); end
    vectors++; if (sv_seen !== 1'b0) begin miscompares++; $display("FAIL serve_arrive_in_door got sv=%b want 0", sv_seen); end
    vectors++; if ({p8, sf8} !== {8'h04, 3'd5}) begin miscompares++; $display("FAIL serve_after got p=%h sf=%0d want 04 5", p8, sf8); end
  endtask

  task automatic test_door_hold();
    int n;
    req_valid = 1'b1; req_floor = 3'd5;
    tick();
    quiet();
    arrive_valid = 1'b1; arrive_floor = 3'd5;
    tick();
    quiet();
    n = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (do8) n++;
    end
    req_valid = 1'b1; req_floor = 3'd5;
    tick();
    quiet();
    if (do8) n++;
    vectors++; if ({ack8, p8} !== {1'b1, 8'h04}) begin miscompares++; $display("FAIL hold_ack got ack=%b p=%h want 1 04", ack8, p8); end
    for (int i = 0; i < 40; i++) begin
      if (i == 0) begin req_valid = 1'b1; req_floor = 3'd1; end
      else req_valid = 1'b0;
      tick();
      if (!do8) break;
      n++;
    end
    quiet();
    vectors++; if (n !== 26) begin miscompares++; $display("FAIL hold_door_len got %0d want 26", n); end
    vectors++; if (p8 !== 8'h06) begin miscompares++; $display("FAIL hold_other_call got %h want 06", p8); end
  endtask

  task automatic test_range();
    req_valid = 1'b1; req_floor = 3'd7;
    tick();
    quiet();
    vectors++; if ({drop6, ack6, p6} !== {1'b1, 1'b0, 6'h06}) begin miscompares++; $display("FAIL range6_floor7 got drop=%b ack=%b p=%h want 1 0 06", drop6, ack6, p6); end
    vectors++; if ({drop8, ack8, p8} !== {1'b0, 1'b1, 8'h86}) begin miscompares++; $display("FAIL range8_floor7 got drop=%b ack=%b p=%h want 0 1 86", drop8, ack8, p8); end
    req_valid = 1'b1; req_floor = 3'd6;
    tick();
    quiet();
    vectors++; if ({drop6, ack6, p6} !== {1'b1, 1'b0, 6'h06}) begin miscompares++; $display("FAIL range6_floor6 got drop=%b ack=%b p=%h want 1 0 06", drop6, ack6, p6); end
    vectors++; if (p8 !== 8'hC6) begin miscompares++; $display("FAIL range8_floor6 got %h want c6", p8); end
    tick();
    vectors++; if ({drop6, drop8} !== 2'b00) begin miscompares++; $display("FAIL range_drop_pulse got %b want 00", {drop6, drop8}); end
  endtask

  task automatic test_simultaneous();
    req_valid = 1'b1; req_floor = 3'd3;
    arrive_valid = 1'b1; arrive_floor = 3'd3;
    tick();
    quiet();
    vectors++; if ({ack8, sv8, sf8, do8} !== {1'b1, 1'b1, 3'd3, 1'b1}) begin miscompares++; $display("FAIL simul_same got ack=%b sv=%b sf=%0d do=%b want 1 1 3 1", ack8, sv8, sf8, do8); end
    vectors++; if (p8 !== 8'hC6) begin miscompares++; $display("FAIL simul_same_pending got %h want c6", p8); end
    for (int i = 0; i < 40 && do8; i++) tick();
    vectors++; if (do8 !== 1'b0) begin miscompares++; $display("FAIL simul_door_close got %b want 0", do8); end
    arrive_valid = 1'b1; arrive_floor = 3'd0;
    tick();
    quiet();
    vectors++; if ({sv8, do8, p8} !== {1'b0, 1'b0, 8'hC6}) begin miscompares++; $display("FAIL simul_pass_through got sv=%b do=%b p=%h want 0 0 c6", sv8, do8, p8); end
    req_valid = 1'b1; req_floor = 3'd0;
    arrive_valid = 1'b1; arrive_floor = 3'd1;
    tick();
    quiet();
    vectors++; if ({ack8, sv8, sf8, p8} !== {1'b1, 1'b1, 3'd1, 8'hC5}) begin miscompares++; $display("FAIL simul_diff got ack=%b sv=%b sf=%0d p=%h want 1 1 1 c5", ack8, sv8, sf8, p8); end
  endtask

  task automatic test_reset_in_door();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 1'b1; req_floor = 3'd0;
    tick();
    req_floor = 3'd7;
    tick();
    req_floor = 3'd3;
    arrive_valid = 1'b1; arrive_floor = 3'd3;
    tick();
    quiet();
    tick();
    tick();
    vectors++; if ({p8, do8} !== {8'h81, 1'b1}) begin miscompares++; $display("FAIL rstdoor_setup got p=%h do=%b want 81 1", p8, do8); end
    rst = 1'b1;
    tick();
    vectors++; if ({p8, pa8, ack8, drop8, sv8, sf8, do8} !== 15'd0) begin miscompares++; $display("FAIL rstdoor_outputs got p=%h pa=%b ack=%b drop=%b sv=%b sf=%0d do=%b want all 0", p8, pa8, ack8, drop8, sv8, sf8, do8); end
    rst = 1'b0;
    tick();
    vectors++; if ({do8, p8} !== {1'b0, 8'h00}) begin miscompares++; $display("FAIL rstdoor_after got do=%b p=%h want 0 00", do8, p8); end
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    test_reset();
    test_call();
    test_serve();
    test_door_hold();
    test_range();
    test_simultaneous();
    test_reset_in_door();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
